// File: rtl/dec_operand_seq_if.sv
// Purpose: bundles the fetch-side handshake, operand-mux select/data and the
// execute-side handshake of the decode operand sequencer.
// Signals:
//   in_valid/in_ready/in_instr      instruction from fetch
//   mux_sel/mux_data                operand mux select and its combinational output
//   out_valid/out_ready             operand bundle handshake to execute
//   out_class/out_opa/out_opb       bundle payload
//   out_illegal                     a needed source index was out of range
// Modports: slave = sequencer side, master = surrounding pipeline side.
interface dec_operand_seq_if #(
    parameter int unsigned DW   = 16,
    parameter int unsigned SELW = 6
);
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_instr;
    logic [SELW-1:0] mux_sel;
    logic [DW-1:0]   mux_data;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_class;
    logic [DW-1:0]   out_opa;
    logic [DW-1:0]   out_opb;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, mux_data, out_ready,
        output in_ready, mux_sel, out_valid, out_class, out_opa, out_opb, out_illegal
    );

    modport master (
        output in_valid, in_instr, mux_data, out_ready,
        input  in_ready, mux_sel, out_valid, out_class, out_opa, out_opb, out_illegal
    );
endinterface

// File: rtl/dec_operand_seq.sv
// Purpose: decode-stage sequencer that accepts one instruction, walks the
// operand mux select through the sources its op class needs (one per cycle),
// captures the mux output into operand registers and issues the bundle.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   flush  synchronous pipeline flush, overrides accept and issue handshakes
//   bus    dec_operand_seq_if.slave (fetch handshake, mux select/data, execute handshake)
module dec_operand_seq #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NSRC = 18,
    parameter int unsigned SELW = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    dec_operand_seq_if.slave   bus
);
    localparam int unsigned CLSW      = 4;
    localparam logic [CLSW-1:0] CLS_ONE  = CLSW'(8);   // first one-source class
    localparam logic [CLSW-1:0] CLS_NONE = CLSW'(12);  // first no-source class
    localparam logic [SELW-1:0] SEL_LIMIT = SELW'(NSRC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_A  = 2'd1,
        RD_B  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            up_q;
    logic [CLSW-1:0] cls_q, cls_d;
    logic [SELW-1:0] idx_a_q, idx_a_d;
    logic [SELW-1:0] idx_b_q, idx_b_d;
    logic [DW-1:0]   opa_q, opa_d;
    logic [DW-1:0]   opb_q, opb_d;
    logic            valid_q, valid_d;
    logic            ill_q, ill_d;

    logic [CLSW-1:0] in_cls;
    logic [SELW-1:0] in_a;
    logic [SELW-1:0] in_b;
    logic            in_bad;
    logic            ready;
    logic            accept;
    logic [SELW-1:0] sel;

    // Instruction field decode; only indices the class actually reads are range-checked
    assign in_cls = bus.in_instr[15:12];
    assign in_a   = SELW'(bus.in_instr[11:6]);
    assign in_b   = SELW'(bus.in_instr[5:0]);
    assign in_bad = ((in_cls < CLS_NONE) && (in_a >= SEL_LIMIT)) ||
                    ((in_cls < CLS_ONE)  && (in_b >= SEL_LIMIT));

    // up_q keeps in_ready low until the first clock after reset release
    assign ready  = up_q && (state_q == IDLE);
    assign accept = bus.in_valid && ready;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            up_q    <= 1'b0;
            cls_q   <= '0;
            idx_a_q <= '0;
            idx_b_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            up_q    <= 1'b1;
            cls_q   <= cls_d;
            idx_a_q <= idx_a_d;
            idx_b_q <= idx_b_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            valid_q <= valid_d;
            ill_q   <= ill_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        idx_a_d = idx_a_q;
        idx_b_d = idx_b_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        valid_d = valid_q;
        ill_d   = ill_q;

        if (flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ill_d   = 1'b0;
            opa_d   = '0;
            opb_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        cls_d   = in_cls;
                        idx_a_d = in_a;
                        idx_b_d = in_b;
                        opa_d   = '0;
                        opb_d   = '0;
                        ill_d   = in_bad;
                        // Illegal or no-source instructions skip the read cycles
                        if (in_bad || (in_cls >= CLS_NONE)) begin
                            state_d = ISSUE;
                            valid_d = 1'b1;
                        end else begin
                            state_d = RD_A;
                        end
                    end
                end
                RD_A: begin
                    opa_d = bus.mux_data;
                    if (cls_q < CLS_ONE) begin
                        state_d = RD_B;
                    end else begin
                        state_d = ISSUE;
                        valid_d = 1'b1;
                    end
                end
                RD_B: begin
                    opb_d   = bus.mux_data;
                    state_d = ISSUE;
                    valid_d = 1'b1;
                end
                ISSUE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Mux select decodes straight from state so the read happens in the same cycle
    always_comb begin
        sel = '0;
        unique case (state_q)
            RD_A:    sel = idx_a_q;
            RD_B:    sel = idx_b_q;
            default: sel = '0;
        endcase
    end

    assign bus.in_ready    = ready;
    assign bus.mux_sel     = sel;
    assign bus.out_valid   = valid_q;
    assign bus.out_class   = cls_q;
    assign bus.out_opa     = opa_q;
    assign bus.out_opb     = opb_q;
    assign bus.out_illegal = ill_q;
endmodule

// File: tb/tb_dec_operand_seq.sv
// Bench for dec_operand_seq: directed vectors with literal expectations plus a
// queue-based model (per accepted instruction: list of reads, then the bundle)
// compared against the DUT on every falling clock edge.
module tb_dec_operand_seq;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] mux_base;
    int          errors;
    int          checks;
    int          cyc;

    dec_operand_seq_if #(.DW(16), .SELW(6)) bus ();

    dec_operand_seq #(.DW(16), .NSRC(18), .SELW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    // Operand mux stand-in: each source returns base + index
    assign bus.mux_data = mux_base + 16'(bus.mux_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // m_sched holds the pending mux reads of the instruction in flight:
    // bit 6 = operand B, bits 5:0 = source index.
    logic [6:0]  m_sched[$];
    bit          m_valid;
    logic [3:0]  m_cls;
    logic [15:0] m_opa;
    logic [15:0] m_opb;
    bit          m_ill;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
            chk("rst_mux_sel", 32'(bus.mux_sel), 32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_class", 32'(bus.out_class), 32'd0);
            chk("rst_opa", 32'(bus.out_opa), 32'd0);
            chk("rst_opb", 32'(bus.out_opb), 32'd0);
            chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
            m_sched.delete();
            m_valid = 0;
        end else begin
            automatic bit         e_ready = !m_valid && (m_sched.size() == 0);
            automatic logic [5:0] e_sel   = (m_sched.size() > 0) ? m_sched[0][5:0] : 6'd0;
            chk("m_in_ready", 32'(bus.in_ready), 32'(e_ready));
            chk("m_mux_sel", 32'(bus.mux_sel), 32'(e_sel));
            chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("m_out_class", 32'(bus.out_class), 32'(m_cls));
                chk("m_opa", 32'(bus.out_opa), 32'(m_opa));
                chk("m_opb", 32'(bus.out_opb), 32'(m_opb));
                chk("m_illegal", 32'(bus.out_illegal), 32'(m_ill));
            end
            // Inputs are stable from here to the next rising edge: advance the model
            if (flush) begin
                m_sched.delete();
                m_valid = 0;
            end else if (e_ready && bus.in_valid) begin
                automatic logic [3:0] c = bus.in_instr[15:12];
                automatic logic [5:0] a = bus.in_instr[11:6];
                automatic logic [5:0] b = bus.in_instr[5:0];
                automatic bit need_a = (c < 12);
                automatic bit need_b = (c < 8);
                automatic bit ill = (need_a && a >= 18) || (need_b && b >= 18);
                m_cls = c;
                m_opa = 16'd0;
                m_opb = 16'd0;
                m_ill = ill;
                if (ill || !need_a) begin
                    m_valid = 1;
                end else begin
                    m_sched.push_back({1'b0, a});
                    if (need_b) m_sched.push_back({1'b1, b});
                end
            end else if (m_valid) begin
                if (bus.out_ready) m_valid = 0;
            end else if (m_sched.size() > 0) begin
                automatic logic [6:0]  ent = m_sched.pop_front();
                automatic logic [15:0] val = mux_base + 16'(ent[5:0]);
                if (ent[6]) m_opb = val;
                else        m_opa = val;
                if (m_sched.size() == 0) m_valid = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] c, input logic [5:0] a, input logic [5:0] b);
        bus.in_valid = 1'b1;
        bus.in_instr = {c, a, b};
        tick();
        bus.in_valid = 1'b0;
    endtask

    logic [15:0] stream [3];
    int          acc_cyc [3];

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        mux_base = 16'h1000;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = 16'h0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset
        tick();
        tick();
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

        // 1: two-source, B=17 (largest legal index)
        offer(4'd2, 6'd3, 6'd17);
        chk("t1_sel_a", 32'(bus.mux_sel), 32'd3);
        chk("t1_in_ready_busy", 32'(bus.in_ready), 32'd0);
        tick();
        chk("t1_sel_b", 32'(bus.mux_sel), 32'd17);
        chk("t1_valid_early", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_opa", 32'(bus.out_opa), 32'h1003);
        chk("t1_opb", 32'(bus.out_opb), 32'h1011);
        chk("t1_illegal", 32'(bus.out_illegal), 32'd0);
        chk("t1_class", 32'(bus.out_class), 32'd2);
        chk("t1_sel_issue", 32'(bus.mux_sel), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t1_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("t1_idle_ready", 32'(bus.in_ready), 32'd1);

        // 2: one-source with execute back-pressure
        offer(4'd9, 6'd5, 6'd0);
        chk("t2_sel_a", 32'(bus.mux_sel), 32'd5);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t2_hold_opa", 32'(bus.out_opa), 32'h1005);
            chk("t2_hold_opb", 32'(bus.out_opb), 32'h0);
            chk("t2_hold_class", 32'(bus.out_class), 32'd9);
            if (i < 3) tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t2_idle_ready", 32'(bus.in_ready), 32'd1);
        chk("t2_valid_drop", 32'(bus.out_valid), 32'd0);

        // 3: illegal B=18, then no-source class with an unused out-of-range A
        offer(4'd3, 6'd1, 6'd18);
        chk("t3_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_illegal", 32'(bus.out_illegal), 32'd1);
        chk("t3_opa", 32'(bus.out_opa), 32'd0);
        chk("t3_opb", 32'(bus.out_opb), 32'd0);
        chk("t3_sel", 32'(bus.mux_sel), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        offer(4'd13, 6'd63, 6'd0);
        chk("t3b_valid", 32'(bus.out_valid), 32'd1);
        chk("t3b_illegal", 32'(bus.out_illegal), 32'd0);
        chk("t3b_class", 32'(bus.out_class), 32'd13);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // 4: flush in RD_B, then flush racing an offered instruction
        offer(4'd0, 6'd2, 6'd4);
        tick();
        chk("t4_sel_b", 32'(bus.mux_sel), 32'd4);
        flush = 1'b1;
        tick();
        chk("t4_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_flush_ready", 32'(bus.in_ready), 32'd1);
        chk("t4_flush_sel", 32'(bus.mux_sel), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_instr = {4'd12, 6'd0, 6'd0};
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("t4_not_taken_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t4_not_taken_valid", 32'(bus.out_valid), 32'd0);

        // 5: asynchronous reset in RD_A, then a fresh instruction
        offer(4'd1, 6'd6, 6'd7);
        chk("t5_sel_a", 32'(bus.mux_sel), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_sel", 32'(bus.mux_sel), 32'd0);
        chk("t5_async_ready", 32'(bus.in_ready), 32'd0);
        chk("t5_async_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("t5_ready_after", 32'(bus.in_ready), 32'd1);
        offer(4'd4, 6'd10, 6'd11);
        tick();
        tick();
        chk("t5_valid", 32'(bus.out_valid), 32'd1);
        chk("t5_opa", 32'(bus.out_opa), 32'h100a);
        chk("t5_opb", 32'(bus.out_opb), 32'h100b);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // 6: back-to-back two-source stream with execute always ready
        mux_base = 16'h2200;
        stream[0] = {4'd5, 6'd0, 6'd17};
        stream[1] = {4'd7, 6'd16, 6'd1};
        stream[2] = {4'd1, 6'd8, 6'd9};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            automatic int waited = 0;
            automatic logic rdy;
            bus.in_valid = 1'b1;
            bus.in_instr = stream[i];
            forever begin
                rdy = bus.in_ready;
                tick();
                if (rdy) break;
                waited++;
                if (waited > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL t6_accept_timeout: instr %0d not accepted in 20 cycles", i);
                    break;
                end
            end
            acc_cyc[i] = cyc;
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("t6_last_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_last_opa", 32'(bus.out_opa), 32'h2208);
        chk("t6_last_opb", 32'(bus.out_opb), 32'h2209);
        chk("t6_ii_01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
        chk("t6_ii_12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
        tick();
        bus.out_ready = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dec_operand_seq.md
Name: dec_operand_seq

Overview:
- Decode-stage sequencer that owns the select input of the 18-source, 16-bit decode operand mux.
- Accepts one instruction word from fetch over a valid/ready handshake.
- Steps the mux select through the instruction's source indices, one per cycle, and captures the mux output into operand registers.
- Presents the opcode class plus operands to execute over a second valid/ready handshake. Illegal source indices are flagged, not read.

Parameters:
- DW, 16, operand width; matches the mux data width.
- NSRC, 18, number of mux sources; valid indices are 0..NSRC-1.
- SELW, 6, mux select width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  sequencer can accept an instruction.
- in_instr  in  16  [15:12] op class, [11:6] source A index, [5:0] source B index.
- mux_sel  out  SELW  select driven to the operand mux.
- mux_data  in  DW  mux output; combinational from mux_sel.
- out_valid  out  1  operand bundle valid to execute.
- out_ready  in  1  execute accepts the bundle.
- out_class  out  4  captured op class.
- out_opa  out  DW  operand A.
- out_opb  out  DW  operand B.
- out_illegal  out  1  a needed source index was >= NSRC.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE.
  - in_ready=0 while rst_n=0, and 1 from the first clock after release.
  - mux_sel=0, out_valid=0, out_class=0, out_opa=0, out_opb=0, out_illegal=0.
  - Reset mid-sequence discards the instruction in flight.
- Class decode:
  - 0-7: two-source; reads A then B.
  - 8-11: one-source; reads A only; out_opb=0.
  - 12-15: no-source; out_opa=out_opb=0.
  - Only indices the class needs are checked for legality.
- States: IDLE, RD_A, RD_B, ISSUE. All outputs are registered except in_ready and mux_sel, which decode from state.
- IDLE:
  - in_ready=1, mux_sel=0.
  - On in_valid & in_ready, latch in_instr.
  - Any needed index >= NSRC: go to ISSUE with out_illegal=1 and operands 0.
  - Otherwise two- or one-source classes go to RD_A; no-source goes to ISSUE.
- RD_A:
  - in_ready=0, mux_sel=latched source A index.
  - mux_data registers into out_opa at the clock edge.
  - Next state RD_B for two-source classes, else ISSUE.
- RD_B:
  - mux_sel=latched source B index.
  - mux_data registers into out_opb.
  - Next state ISSUE.
- ISSUE:
  - out_valid=1; out_class, out_opa, out_opb and out_illegal are held stable until out_ready=1.
  - On handshake, out_valid goes to 0 next cycle and state returns to IDLE.
  - in_ready=0; there is no overlap with the next accept.
- Latency from the accept edge to out_valid=1: two-source 3 cycles, one-source 2, no-source or illegal 1. Minimum initiation interval = latency + 1 (IDLE cycle).
- mux_sel=0 in IDLE and ISSUE.
- flush=1 at any edge:
  - Next state IDLE, out_valid=0, out_illegal=0; operands cleared to 0.
  - flush has priority over an accept and over an out handshake in the same cycle, so an instruction offered with flush is not taken.
- out_ready is ignored when out_valid=0.
- in_valid is ignored outside IDLE.
- Index boundaries: 17 is legal; 18..63 are illegal.

Test Plan:
1. Reset, then accept class 2, A=3, B=17 with mux_data = 0x1000+sel → mux_sel 3 then 17 on consecutive cycles; out_valid 3 cycles after accept with opa=0x1003, opb=0x1011, illegal=0.
2. Class 9, A=5, out_ready held 0 for 4 cycles → opa=0x1005, opb=0; out_valid and all bundle fields stable for those 4 cycles; IDLE one cycle after out_ready=1.
3. Class 3, B=18 → no RD cycles, mux_sel stays 0; out_valid 1 cycle after accept with illegal=1, opa=opb=0. Class 13 with A=63 → illegal=0, since the index is unused.
4. flush asserted in RD_B → next cycle IDLE, out_valid=0, in_ready=1. flush with in_valid in IDLE → instruction not accepted.
5. rst_n pulsed low asynchronously during RD_A → all outputs 0 immediately; a fresh instruction after release completes normally.
6. Back-to-back stream of 3 two-source instructions, out_ready=1 throughout → one bundle every 4 cycles with correct operands; in_ready=0 except in IDLE.
